// File: rtl/riscv_mem_arbiter.sv
// Shares one single-port synchronous SRAM between instruction fetch and data memory.
// Data accesses win ties unless IF has watched MAX_DM_STREAK DM grants in a row.
module riscv_mem_arbiter #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_LATENCY   = 1,
  parameter int MAX_DM_STREAK = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  output logic                    if_ready,
  input  logic                    dm_req,
  input  logic                    dm_we,
  input  logic [ADDR_WIDTH-1:0]   dm_addr,
  input  logic [DATA_WIDTH-1:0]   dm_wdata,
  input  logic [DATA_WIDTH/8-1:0] dm_wstrb,
  output logic [DATA_WIDTH-1:0]   dm_rdata,
  output logic                    dm_ready,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    busy
);

  localparam int STRB_WIDTH   = DATA_WIDTH / 8;
  localparam int STREAK_WIDTH = $clog2(MAX_DM_STREAK + 1);
  localparam int LAT_WIDTH    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [STREAK_WIDTH-1:0] STREAK_MAX = STREAK_WIDTH'(MAX_DM_STREAK);
  localparam logic [LAT_WIDTH-1:0]    LAT_LOAD   = LAT_WIDTH'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  state_t                  state_reg,     state_next;
  logic                    owner_dm_reg,  owner_dm_next;
  logic [STREAK_WIDTH-1:0] dm_streak_reg, dm_streak_next;
  logic [LAT_WIDTH-1:0]    lat_cnt_reg,   lat_cnt_next;
  logic                    mem_en_reg,    mem_en_next;
  logic                    mem_we_reg,    mem_we_next;
  logic [ADDR_WIDTH-1:0]   mem_addr_reg,  mem_addr_next;
  logic [DATA_WIDTH-1:0]   mem_wdata_reg, mem_wdata_next;
  logic [STRB_WIDTH-1:0]   mem_wstrb_reg, mem_wstrb_next;

  logic streak_full;
  logic grant_dm;

  assign streak_full = (dm_streak_reg == STREAK_MAX);
  // IF only overrides DM once it has been passed over MAX_DM_STREAK times.
  assign grant_dm    = dm_req && !(if_req && streak_full);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      owner_dm_reg  <= 1'b0;
      dm_streak_reg <= '0;
      lat_cnt_reg   <= '0;
      mem_en_reg    <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      mem_wstrb_reg <= '0;
    end else begin
      state_reg     <= state_next;
      owner_dm_reg  <= owner_dm_next;
      dm_streak_reg <= dm_streak_next;
      lat_cnt_reg   <= lat_cnt_next;
      mem_en_reg    <= mem_en_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      mem_wstrb_reg <= mem_wstrb_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    owner_dm_next  = owner_dm_reg;
    dm_streak_next = dm_streak_reg;
    lat_cnt_next   = lat_cnt_reg;
    mem_en_next    = 1'b0;
    mem_we_next    = mem_we_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    mem_wstrb_next = mem_wstrb_reg;

    unique case (state_reg)
      IDLE: begin
        if (if_req || dm_req) begin
          state_next  = ISSUE;
          mem_en_next = 1'b1;
          if (grant_dm) begin
            owner_dm_next  = 1'b1;
            mem_we_next    = dm_we;
            mem_addr_next  = dm_addr;
            mem_wdata_next = dm_wdata;
            mem_wstrb_next = dm_we ? dm_wstrb : '0;
            if (if_req) begin
              dm_streak_next = streak_full ? STREAK_MAX : dm_streak_reg + 1'b1;
            end else begin
              dm_streak_next = '0;
            end
          end else begin
            owner_dm_next  = 1'b0;
            mem_we_next    = 1'b0;
            mem_addr_next  = if_addr;
            mem_wdata_next = '0;
            mem_wstrb_next = '0;
            dm_streak_next = '0;
          end
        end
      end
      ISSUE: begin
        lat_cnt_next = LAT_LOAD;
        state_next   = (MEM_LATENCY == 1) ? DONE : WAIT;
      end
      WAIT: begin
        lat_cnt_next = lat_cnt_reg - 1'b1;
        if (lat_cnt_reg <= LAT_WIDTH'(1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        // The requester changes req/addr on the edge ending DONE, so never re-grant here.
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign mem_en    = mem_en_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign mem_wstrb = mem_wstrb_reg;

  assign busy      = (state_reg != IDLE);
  assign if_ready  = (state_reg == DONE) && !owner_dm_reg;
  assign dm_ready  = (state_reg == DONE) &&  owner_dm_reg;
  assign if_rdata  = if_ready ? mem_rdata : '0;
  assign dm_rdata  = (dm_ready && !mem_we_reg) ? mem_rdata : '0;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench: dut_a runs with MEM_LATENCY=1, dut_b with MEM_LATENCY=3, each with its own SRAM model.
module tb_riscv_mem_arbiter;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic        a_rst, a_if_req, a_if_ready, a_dm_req, a_dm_we, a_dm_ready;
  logic        a_mem_en, a_mem_we, a_busy;
  logic [31:0] a_if_addr, a_if_rdata, a_dm_addr, a_dm_wdata, a_dm_rdata;
  logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic [3:0]  a_dm_wstrb, a_mem_wstrb;

  logic        b_rst, b_if_req, b_if_ready, b_dm_req, b_dm_we, b_dm_ready;
  logic        b_mem_en, b_mem_we, b_busy;
  logic [31:0] b_if_addr, b_if_rdata, b_dm_addr, b_dm_wdata, b_dm_rdata;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [3:0]  b_dm_wstrb, b_mem_wstrb;

  logic [4:0] a_flags, b_flags;
  assign a_flags = {a_mem_en, a_mem_we, a_busy, a_if_ready, a_dm_ready};
  assign b_flags = {b_mem_en, b_mem_we, b_busy, b_if_ready, b_dm_ready};

  riscv_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(1), .MAX_DM_STREAK(4)) dut_a (
    .clk(clk), .rst(a_rst),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_rdata(a_if_rdata), .if_ready(a_if_ready),
    .dm_req(a_dm_req), .dm_we(a_dm_we), .dm_addr(a_dm_addr), .dm_wdata(a_dm_wdata),
    .dm_wstrb(a_dm_wstrb), .dm_rdata(a_dm_rdata), .dm_ready(a_dm_ready),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_wstrb(a_mem_wstrb), .mem_rdata(a_mem_rdata), .busy(a_busy)
  );

  riscv_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(3), .MAX_DM_STREAK(4)) dut_b (
    .clk(clk), .rst(b_rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ready(b_if_ready),
    .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata),
    .dm_wstrb(b_dm_wstrb), .dm_rdata(b_dm_rdata), .dm_ready(b_dm_ready),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_wstrb(b_mem_wstrb), .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  // SRAM models with a preload port; word index is addr[9:2].
  logic [31:0] mem_a [0:255];
  logic [31:0] mem_b [0:255];
  logic        a_pl_en, b_pl_en;
  logic [7:0]  a_pl_idx, b_pl_idx;
  logic [31:0] a_pl_data, b_pl_data;
  logic [31:0] b_p0, b_p1;

  always @(posedge clk) begin
    if (a_pl_en) begin
      mem_a[a_pl_idx] <= a_pl_data;
    end else if (a_mem_en && a_mem_we) begin
      for (int k = 0; k < 4; k++) begin
        if (a_mem_wstrb[k]) mem_a[a_mem_addr[9:2]][8*k +: 8] <= a_mem_wdata[8*k +: 8];
      end
    end
    if (a_mem_en && !a_mem_we) a_mem_rdata <= mem_a[a_mem_addr[9:2]];
  end

  always @(posedge clk) begin
    if (b_pl_en) begin
      mem_b[b_pl_idx] <= b_pl_data;
    end else if (b_mem_en && b_mem_we) begin
      for (int k = 0; k < 4; k++) begin
        if (b_mem_wstrb[k]) mem_b[b_mem_addr[9:2]][8*k +: 8] <= b_mem_wdata[8*k +: 8];
      end
    end
    if (b_mem_en && !b_mem_we) b_p0 <= mem_b[b_mem_addr[9:2]];
    b_p1        <= b_p0;
    b_mem_rdata <= b_p1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] ia, input logic [31:0] da,
                         input logic [7:0] ib, input logic [31:0] db);
    a_pl_en = 1'b1; a_pl_idx = ia; a_pl_data = da;
    b_pl_en = 1'b1; b_pl_idx = ib; b_pl_data = db;
    step();
    a_pl_en = 1'b0;
    b_pl_en = 1'b0;
  endtask

  // Steps dut_a until n ready pulses; order bit i is 1 when grant i went to IF.
  task automatic run_grants(input int n, input logic if_after, input logic dm_after,
                            output logic [15:0] order, output int got,
                            output logic both_seen, output logic en_twice);
    logic prev_en;
    order = '0; got = 0; both_seen = 1'b0; en_twice = 1'b0; prev_en = 1'b0;
    for (int c = 0; c < 40 * n && got < n; c++) begin
      step();
      if (a_if_ready && a_dm_ready) both_seen = 1'b1;
      if (a_mem_en && prev_en) en_twice = 1'b1;
      prev_en = a_mem_en;
      if (a_if_ready || a_dm_ready) begin
        order[got] = a_if_ready;
        got++;
        if (got == n) begin
          a_if_req = if_after;
          a_dm_req = dm_after;
        end
      end
    end
  endtask

  task automatic test_reset();
    a_rst = 1'b1; b_rst = 1'b1;
    a_if_req = 0; a_dm_req = 0; a_dm_we = 0; a_if_addr = 0; a_dm_addr = 0; a_dm_wdata = 0; a_dm_wstrb = 0;
    b_if_req = 0; b_dm_req = 0; b_dm_we = 0; b_if_addr = 0; b_dm_addr = 0; b_dm_wdata = 0; b_dm_wstrb = 0;
    a_pl_en = 0; a_pl_idx = 0; a_pl_data = 0;
    b_pl_en = 0; b_pl_idx = 0; b_pl_data = 0;
    step();
    preload(8'h04, 32'h00500093, 8'h80, 32'h12345678);
    preload(8'h08, 32'h00000013, 8'h08, 32'h00000013);
    preload(8'h40, 32'h11223344, 8'h80, 32'h12345678);
    preload(8'h10, 32'hCAFEF00D, 8'h08, 32'h00000013);
    n_cmp++; if (a_flags !== 5'b00000) begin n_err++; $display("FAIL reset_a_flags: got %b want %b", a_flags, 5'b00000); end
    n_cmp++; if (b_flags !== 5'b00000) begin n_err++; $display("FAIL reset_b_flags: got %b want %b", b_flags, 5'b00000); end
    n_cmp++; if ({a_mem_addr, a_mem_wdata, a_mem_wstrb, a_if_rdata, a_dm_rdata} !== 132'd0) begin
      n_err++; $display("FAIL reset_a_data: got %h/%h/%h/%h/%h want all 0", a_mem_addr, a_mem_wdata, a_mem_wstrb, a_if_rdata, a_dm_rdata);
    end
    a_rst = 1'b0; b_rst = 1'b0;
    step();
    n_cmp++; if (a_flags !== 5'b00000) begin n_err++; $display("FAIL reset_release_flags: got %b want %b", a_flags, 5'b00000); end
    $display("reset: done");
  endtask

  task automatic test_single_if();
    a_if_req = 1'b1; a_if_addr = 32'h10;
    n_cmp++; if (a_flags !== 5'b00000) begin n_err++; $display("FAIL single_if_c0: got %b want %b", a_flags, 5'b00000); end
    step();
    n_cmp++; if (a_flags !== 5'b10100) begin n_err++; $display("FAIL single_if_c1: got %b want %b", a_flags, 5'b10100); end
    n_cmp++; if (a_mem_addr !== 32'h10) begin n_err++; $display("FAIL single_if_addr: got %h want %h", a_mem_addr, 32'h10); end
    step();
    n_cmp++; if (a_flags !== 5'b00110) begin n_err++; $display("FAIL single_if_c2: got %b want %b", a_flags, 5'b00110); end
    n_cmp++; if (a_if_rdata !== 32'h00500093) begin n_err++; $display("FAIL single_if_rdata: got %h want %h", a_if_rdata, 32'h00500093); end
    n_cmp++; if (a_dm_rdata !== 32'h0) begin n_err++; $display("FAIL single_if_dm_rdata: got %h want 0", a_dm_rdata); end
    a_if_req = 1'b0;
    step();
    n_cmp++; if (a_flags !== 5'b00000) begin n_err++; $display("FAIL single_if_c3: got %b want %b", a_flags, 5'b00000); end
    $display("single_if: addr 10 rdata %h", a_mem_rdata);
  endtask

  task automatic test_simultaneous();
    a_if_req = 1'b1; a_if_addr = 32'h20;
    a_dm_req = 1'b1; a_dm_we = 1'b1; a_dm_addr = 32'h100; a_dm_wdata = 32'hDEADBEEF; a_dm_wstrb = 4'b0011;
    step();
    n_cmp++; if (a_flags !== 5'b11100) begin n_err++; $display("FAIL simul_c1: got %b want %b", a_flags, 5'b11100); end
    n_cmp++; if ({a_mem_addr, a_mem_wdata, a_mem_wstrb} !== {32'h100, 32'hDEADBEEF, 4'b0011}) begin
      n_err++; $display("FAIL simul_cmd: got %h/%h/%b want 100/deadbeef/0011", a_mem_addr, a_mem_wdata, a_mem_wstrb);
    end
    step();
    n_cmp++; if (a_flags !== 5'b01101) begin n_err++; $display("FAIL simul_c2: got %b want %b", a_flags, 5'b01101); end
    n_cmp++; if (a_dm_rdata !== 32'h0) begin n_err++; $display("FAIL simul_write_rdata: got %h want 0", a_dm_rdata); end
    a_dm_req = 1'b0; a_dm_we = 1'b0;
    step();
    n_cmp++; if (a_flags !== 5'b01000) begin n_err++; $display("FAIL simul_c3: got %b want %b", a_flags, 5'b01000); end
    step();
    n_cmp++; if (a_flags !== 5'b10100) begin n_err++; $display("FAIL simul_c4: got %b want %b", a_flags, 5'b10100); end
    n_cmp++; if ({a_mem_addr, a_mem_wstrb} !== {32'h20, 4'b0000}) begin
      n_err++; $display("FAIL simul_if_cmd: got %h/%b want 20/0000", a_mem_addr, a_mem_wstrb);
    end
    step();
    n_cmp++; if (a_flags !== 5'b00110) begin n_err++; $display("FAIL simul_c5: got %b want %b", a_flags, 5'b00110); end
    n_cmp++; if (a_if_rdata !== 32'h00000013) begin n_err++; $display("FAIL simul_if_rdata: got %h want %h", a_if_rdata, 32'h00000013); end
    a_if_req = 1'b0;
    step();
    $display("simultaneous: dm write 100 then if read 20");
  endtask

  task automatic test_back_to_back();
    a_dm_req = 1'b1; a_dm_we = 1'b0; a_dm_addr = 32'h100;
    step();
    n_cmp++; if (a_flags !== 5'b10100) begin n_err++; $display("FAIL b2b_c1: got %b want %b", a_flags, 5'b10100); end
    step();
    n_cmp++; if (a_flags !== 5'b00101) begin n_err++; $display("FAIL b2b_c2: got %b want %b", a_flags, 5'b00101); end
    n_cmp++; if (a_dm_rdata !== 32'h1122BEEF) begin n_err++; $display("FAIL b2b_strobed_rdata: got %h want %h", a_dm_rdata, 32'h1122BEEF); end
    a_dm_addr = 32'h40;
    step();
    n_cmp++; if (a_flags !== 5'b00000) begin n_err++; $display("FAIL b2b_c3: got %b want %b", a_flags, 5'b00000); end
    step();
    n_cmp++; if (a_flags !== 5'b10100 || a_mem_addr !== 32'h40) begin
      n_err++; $display("FAIL b2b_c4: got %b/%h want 10100/40", a_flags, a_mem_addr);
    end
    step();
    n_cmp++; if (a_dm_rdata !== 32'hCAFEF00D || a_flags !== 5'b00101) begin
      n_err++; $display("FAIL b2b_c5: got %h/%b want cafef00d/00101", a_dm_rdata, a_flags);
    end
    a_dm_req = 1'b0;
    step();
    $display("back_to_back: two dm reads 3 cycles apart");
  endtask

  task automatic test_starvation();
    logic [15:0] order;
    int          got;
    logic        both_seen, en_twice;
    a_if_req = 1'b1; a_if_addr = 32'h20;
    a_dm_req = 1'b1; a_dm_we = 1'b0; a_dm_addr = 32'h100;
    run_grants(10, 1'b0, 1'b0, order, got, both_seen, en_twice);
    n_cmp++; if (got !== 10) begin n_err++; $display("FAIL starve_count: got %0d want 10", got); end
    n_cmp++; if (order[9:0] !== 10'b1000010000) begin n_err++; $display("FAIL starve_order: got %b want %b", order[9:0], 10'b1000010000); end
    n_cmp++; if (both_seen !== 1'b0) begin n_err++; $display("FAIL starve_both_ready: got %b want 0", both_seen); end
    n_cmp++; if (en_twice !== 1'b0) begin n_err++; $display("FAIL starve_en_consecutive: got %b want 0", en_twice); end
    step();
    $display("starvation: order %b", order[9:0]);
  endtask

  task automatic test_streak_clear();
    logic [15:0] order;
    int          got;
    logic        both_seen, en_twice;
    a_if_req = 1'b1; a_dm_req = 1'b1; a_dm_we = 1'b0; a_dm_addr = 32'h100; a_if_addr = 32'h20;
    run_grants(3, 1'b0, 1'b1, order, got, both_seen, en_twice);
    n_cmp++; if (got !== 3 || order[2:0] !== 3'b000) begin n_err++; $display("FAIL streak_build: got %0d/%b want 3/000", got, order[2:0]); end
    run_grants(3, 1'b1, 1'b1, order, got, both_seen, en_twice);
    n_cmp++; if (got !== 3 || order[2:0] !== 3'b000) begin n_err++; $display("FAIL streak_dm_only: got %0d/%b want 3/000", got, order[2:0]); end
    run_grants(5, 1'b0, 1'b0, order, got, both_seen, en_twice);
    n_cmp++; if (got !== 5 || order[4:0] !== 5'b10000) begin n_err++; $display("FAIL streak_cleared: got %0d/%b want 5/10000", got, order[4:0]); end
    step();
    $display("streak_clear: order after clear %b", order[4:0]);
  endtask

  task automatic test_latency();
    b_dm_req = 1'b1; b_dm_we = 1'b0; b_dm_addr = 32'h200;
    step();
    n_cmp++; if (b_flags !== 5'b10100 || b_mem_addr !== 32'h200) begin
      n_err++; $display("FAIL lat_c1: got %b/%h want 10100/200", b_flags, b_mem_addr);
    end
    step();
    n_cmp++; if (b_flags !== 5'b00100) begin n_err++; $display("FAIL lat_c2: got %b want %b", b_flags, 5'b00100); end
    step();
    n_cmp++; if (b_flags !== 5'b00100) begin n_err++; $display("FAIL lat_c3: got %b want %b", b_flags, 5'b00100); end
    step();
    n_cmp++; if (b_flags !== 5'b00101) begin n_err++; $display("FAIL lat_c4: got %b want %b", b_flags, 5'b00101); end
    n_cmp++; if (b_dm_rdata !== 32'h12345678) begin n_err++; $display("FAIL lat_rdata: got %h want %h", b_dm_rdata, 32'h12345678); end
    b_dm_req = 1'b0;
    step();
    n_cmp++; if (b_flags !== 5'b00000) begin n_err++; $display("FAIL lat_c5: got %b want %b", b_flags, 5'b00000); end
    $display("latency: dm read 200 rdata %h", b_mem_rdata);
  endtask

  task automatic test_reset_mid();
    b_dm_req = 1'b1; b_dm_we = 1'b0; b_dm_addr = 32'h200;
    step();
    step();
    b_rst = 1'b1; b_dm_req = 1'b0;
    step();
    n_cmp++; if (b_flags !== 5'b00000) begin n_err++; $display("FAIL rstmid_c3: got %b want %b", b_flags, 5'b00000); end
    n_cmp++; if ({b_mem_addr, b_mem_wdata, b_mem_wstrb, b_if_rdata, b_dm_rdata} !== 132'd0) begin
      n_err++; $display("FAIL rstmid_data: got %h/%h/%h/%h/%h want all 0", b_mem_addr, b_mem_wdata, b_mem_wstrb, b_if_rdata, b_dm_rdata);
    end
    step();
    b_rst = 1'b0;
    n_cmp++; if (b_flags !== 5'b00000) begin n_err++; $display("FAIL rstmid_c4: got %b want %b", b_flags, 5'b00000); end
    step();
    b_if_req = 1'b1; b_if_addr = 32'h20;
    n_cmp++; if (b_flags !== 5'b00000) begin n_err++; $display("FAIL rstmid_c5: got %b want %b", b_flags, 5'b00000); end
    step();
    n_cmp++; if (b_flags !== 5'b10100 || b_mem_addr !== 32'h20) begin
      n_err++; $display("FAIL rstmid_if_grant: got %b/%h want 10100/20", b_flags, b_mem_addr);
    end
    step();
    step();
    n_cmp++; if (b_flags !== 5'b00100) begin n_err++; $display("FAIL rstmid_c8: got %b want %b", b_flags, 5'b00100); end
    step();
    n_cmp++; if (b_flags !== 5'b00110 || b_if_rdata !== 32'h00000013) begin
      n_err++; $display("FAIL rstmid_if_done: got %b/%h want 00110/00000013", b_flags, b_if_rdata);
    end
    b_if_req = 1'b0;
    step();
    $display("reset_mid: dm read discarded, if read 20 completed");
  endtask

  initial begin
    test_reset();
    test_single_if();
    test_simultaneous();
    test_back_to_back();
    test_starvation();
    test_streak_clear();
    test_latency();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/riscv_mem_arbiter.md
# riscv_mem_arbiter

Two-port to single-port memory arbiter for the 5-stage RISC-V pipeline. It shares one unified single-port synchronous SRAM between the instruction-fetch port (IF stage) and the data-memory port (MEM stage). Data accesses have priority, and a streak counter keeps instruction fetch from starving. The pipeline's hazard logic treats a pending request without `*_ready` as a stall (`Stall_F` / MEM-stage stall).

## Interface

Parameters:

- `ADDR_WIDTH`, 32: byte address width.
- `DATA_WIDTH`, 32: data width; the strobe width is `DATA_WIDTH/8`.
- `MEM_LATENCY`, 1: cycles from the cycle `mem_en` is sampled to valid `mem_rdata`. Legal range is 1 or more.
- `MAX_DM_STREAK`, 4: consecutive DM grants allowed while IF is waiting before IF is forced. Legal range is 1 or more.

Ports:

- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous reset, active-high.
- `if_req`  in  1: IF read request; held until `if_ready`.
- `if_addr`  in  ADDR_WIDTH: fetch address; stable while `if_req` is high.
- `if_rdata`  out  DATA_WIDTH: instruction word; valid only while `if_ready` is high.
- `if_ready`  out  1: one-cycle completion pulse for IF.
- `dm_req`  in  1: DM request; held until `dm_ready`.
- `dm_we`  in  1: 1 means write, 0 means read.
- `dm_addr`  in  ADDR_WIDTH: data address.
- `dm_wdata`  in  DATA_WIDTH: write data.
- `dm_wstrb`  in  DATA_WIDTH/8: byte-enable for writes (SB/SH/SW).
- `dm_rdata`  out  DATA_WIDTH: load data; valid only while `dm_ready` is high.
- `dm_ready`  out  1: one-cycle completion pulse for DM.
- `mem_en`  out  1: SRAM access strobe, registered.
- `mem_we`  out  1: SRAM write enable, registered.
- `mem_addr`  out  ADDR_WIDTH: SRAM address, registered.
- `mem_wdata`  out  DATA_WIDTH: SRAM write data, registered.
- `mem_wstrb`  out  DATA_WIDTH/8: SRAM byte strobe, registered; 0 on reads.
- `mem_rdata`  in  DATA_WIDTH: SRAM read data.
- `busy`  out  1: high in any state other than IDLE.

## Operation

States are IDLE, ISSUE, WAIT and DONE. Each state records the owner, IF or DM.

- **IDLE:** if any request is high, the arbiter selects a winner and registers the command (`mem_en`=1 and the address/data/we/strb of the winner), then moves to ISSUE. With no request it stays in IDLE.
- **Selection:**
  - DM only: DM wins.
  - IF only: IF wins.
  - Both: DM wins unless `dm_streak == MAX_DM_STREAK`, in which case IF wins.
- **dm_streak update:**
  - DM grant while `if_req` is high: `dm_streak` increments, saturating at `MAX_DM_STREAK`.
  - DM grant while `if_req` is low: `dm_streak` clears to 0.
  - Any IF grant: `dm_streak` clears to 0.
- **ISSUE (1 cycle):**
  - `mem_en` is high for this cycle only and is cleared at the end of ISSUE.
  - A latency counter loads `MEM_LATENCY-1`.
  - If `MEM_LATENCY`=1, the next state is DONE; otherwise it is WAIT.
- **WAIT:** the counter decrements each cycle; the arbiter moves to DONE when it reaches 1.
- **DONE (1 cycle):**
  - The owner's `*_ready` is high for this cycle.
  - Its `*_rdata` is `mem_rdata` passed through combinationally. For DM writes, `dm_rdata` is 0.
  - The non-owner's `ready` stays 0 and its `rdata` is 0.
  - Next state is always IDLE. There is no re-grant in DONE, because the requester updates its `req`/`addr` on the edge ending DONE.
- **Registered command outputs:** they hold their last value while `mem_en`=0. Only `mem_en` qualifies them.
- **Protocol violation:** a requester dropping `req` before `ready` is not checked. The transaction still completes and `ready` still pulses.

## Timing

- **Reset:** with `rst` high at an edge, the arbiter enters IDLE and `dm_streak` and the latency counter clear to 0.
  - All outputs are 0 from the next cycle: `mem_*`, `*_ready`, `*_rdata`, `busy`.
  - An in-flight transaction is discarded and no `ready` is issued for it.
  - Reset takes precedence over all other events in the same cycle.
- **Access timeline:** a request is seen in IDLE in cycle 0.
  - `mem_en` is high in cycle 1.
  - `*_ready` is high in cycle 1+`MEM_LATENCY`.
  - The arbiter is back in IDLE in cycle 2+`MEM_LATENCY`.
- **Throughput:** one access per 2+`MEM_LATENCY` cycles; for `MEM_LATENCY`=1 that is one access every 3 cycles.
- **Grant timing:** a request arriving while `busy` is high waits. It is evaluated in the next IDLE cycle, together with any other pending request.
- **Ready and memory outputs:** `if_ready` and `dm_ready` are never high together. `mem_en` is never high in two consecutive cycles.

## Test plan

- **Reset mid-transaction:** DM read granted with `MEM_LATENCY`=3, then `rst` high for 2 cycles during WAIT. Required: `dm_ready` never pulses and all outputs are 0. An `if_req` issued 1 cycle after reset release gets `mem_en` 1 cycle later.
- **Single IF read:** `MEM_LATENCY`=1, `if_addr`=0x00000010, SRAM model returns 0x00500093.
  - `mem_en`=1 and `mem_we`=0 in cycle 1 only.
  - `if_ready`=1 in cycle 2 with `if_rdata`=0x00500093.
  - `busy`=0 in cycle 3.
- **Simultaneous requests:** in cycle 0, IF requests addr 0x20 and DM writes addr 0x100, data 0xDEADBEEF, wstrb 4'b0011.
  - DM goes first: cycle 1 has `mem_we`=1 and `mem_wstrb`=0011; `dm_ready` in cycle 2 with `dm_rdata`=0.
  - IF follows: `mem_en` in cycle 4, `if_ready` in cycle 5.
- **Starvation guard:** `MAX_DM_STREAK`=4, `if_req` held continuously, `dm_req` re-raised after every `dm_ready`. Required grant order: DM, DM, DM, DM, IF, DM, DM, DM, DM, IF.
- **Latency parameter:** `MEM_LATENCY`=3 and a DM read of 0x200 returning 0x12345678. Required: `mem_en` for exactly 1 cycle (cycle 1), `dm_ready` in cycle 4 with `dm_rdata`=0x12345678.
- **DM streak clears with no IF pending:** 3 DM grants with `if_req` low, then both requesting. Required: DM wins, showing the streak was cleared rather than carried.
